// File: rtl/hash_round_sequencer.sv
// -----------------------------------------------------------------------------
// hash_round_sequencer
//
// Controller for the shared hash datapath. It serialises permutation requests
// from a Haraka requester and a Keccak requester, with round-robin arbitration
// when both ask at once. For the granted operation it drives the round indices
// and enables of the Haraka round/AES/mix engine or the Keccak-f engine. It then
// returns a one-cycle done pulse to the requester that was granted.
//
// Every output is a register and clears asynchronously on reset.
//
// Optional build macro: HASH_SEQ_PERF_EN
//   Adds three performance counters: perf_haraka_cnt, perf_keccak_cnt and
//   perf_busy_cycles.
//
// Ports
//   clock            in   system clock, rising edge
//   reset            in   asynchronous, active-high reset
//   haraka_req       in   Haraka request, held until haraka_done
//   haraka_mode      in   0 = Haraka-256, 1 = Haraka-512, sampled at grant
//   haraka_done      out  one-cycle pulse when the Haraka permutation completes
//   keccak_req       in   Keccak-f request, held until keccak_done
//   keccak_done      out  one-cycle pulse when the Keccak-f permutation completes
//   busy             out  high whenever the FSM is outside IDLE
//   we               out  feed-forward latch enable (Haraka load cycle)
//   hara_c           out  latched haraka_mode while a Haraka operation runs
//   round            out  Haraka round index, 0..HARAKA_ROUNDS-1
//   round_aes        out  AES step within a Haraka round, 0..1
//   haraka_start     out  Haraka state writeback enable
//   end_round        out  selects the feed-forward output on the final step
//   keccak_rst       out  Keccak engine init strobe
//   keccak_f_start   out  Keccak state writeback enable
//   keccak_round     out  Keccak round index, 0..KECCAK_ROUNDS-1
//   perf_*           out  operation and busy-cycle counters (HASH_SEQ_PERF_EN)
// -----------------------------------------------------------------------------
module hash_round_sequencer #(
  parameter int HARAKA_ROUNDS = 5,
  parameter int KECCAK_ROUNDS = 24
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        haraka_req,
  input  logic        haraka_mode,
  output logic        haraka_done,
  input  logic        keccak_req,
  output logic        keccak_done,
  output logic        busy,
  output logic        we,
  output logic        hara_c,
  output logic [3:0]  round,
  output logic [1:0]  round_aes,
  output logic        haraka_start,
  output logic        end_round,
  output logic        keccak_rst,
  output logic        keccak_f_start,
  output logic [4:0]  keccak_round
`ifdef HASH_SEQ_PERF_EN
  ,
  output logic [31:0] perf_haraka_cnt,
  output logic [31:0] perf_keccak_cnt,
  output logic [31:0] perf_busy_cycles
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    H_LOAD,
    H_RUN,
    K_INIT,
    K_RUN,
    DONE
  } state_t;

  typedef enum logic {
    GRANT_HARAKA,
    GRANT_KECCAK
  } grant_t;

  localparam logic [3:0] H_LAST = 4'(HARAKA_ROUNDS - 1);
  localparam logic [4:0] K_LAST = 5'(KECCAK_ROUNDS - 1);

  state_t state;
  grant_t last_grant;

  // Haraka wins an IDLE decision if it asks alone, or if both ask and Keccak
  // was granted last time.
  logic grant_haraka;
  assign grant_haraka = haraka_req && (!keccak_req || last_grant == GRANT_KECCAK);

  // Each output is assigned the value that matches the state being entered.
  // That keeps every output a plain flop while it still lines up cycle-for-cycle
  // with the FSM state.
  // NOTE: state and outputs are flops, so they use non-blocking assignments
  // only. A blocking assignment here would let later statements see
  // same-cycle values and would break the registered timing.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      last_grant     <= GRANT_KECCAK;
      haraka_done    <= 1'b0;
      keccak_done    <= 1'b0;
      busy           <= 1'b0;
      we             <= 1'b0;
      hara_c         <= 1'b0;
      round          <= '0;
      round_aes      <= '0;
      haraka_start   <= 1'b0;
      end_round      <= 1'b0;
      keccak_rst     <= 1'b0;
      keccak_f_start <= 1'b0;
      keccak_round   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_haraka) begin
            state      <= H_LOAD;
            last_grant <= GRANT_HARAKA;
            busy       <= 1'b1;
            we         <= 1'b1;
            hara_c     <= haraka_mode;
            round      <= '0;
            round_aes  <= '0;
          end else if (keccak_req) begin
            state        <= K_INIT;
            last_grant   <= GRANT_KECCAK;
            busy         <= 1'b1;
            keccak_rst   <= 1'b1;
            keccak_round <= '0;
          end
        end

        H_LOAD: begin
          state        <= H_RUN;
          we           <= 1'b0;
          haraka_start <= 1'b1;
        end

        H_RUN: begin
          if (round_aes == 2'd0) begin
            // end_round is raised together with the final (H_LAST, 1) step.
            round_aes <= 2'd1;
            end_round <= (round == H_LAST);
          end else if (round == H_LAST) begin
            state        <= DONE;
            haraka_start <= 1'b0;
            end_round    <= 1'b0;
            hara_c       <= 1'b0;
            round        <= '0;
            round_aes    <= '0;
            haraka_done  <= 1'b1;
          end else begin
            round     <= round + 4'd1;
            round_aes <= 2'd0;
          end
        end

        K_INIT: begin
          state          <= K_RUN;
          keccak_rst     <= 1'b0;
          keccak_f_start <= 1'b1;
        end

        K_RUN: begin
          // Leave on the last index so that keccak_round never shows KECCAK_ROUNDS.
          if (keccak_round == K_LAST) begin
            state          <= DONE;
            keccak_f_start <= 1'b0;
            keccak_round   <= '0;
            keccak_done    <= 1'b1;
          end else begin
            keccak_round <= keccak_round + 5'd1;
          end
        end

        DONE: begin
          // Requests are not examined here. A requester that drops req on
          // seeing done therefore cannot be granted a second time.
          state       <= IDLE;
          busy        <= 1'b0;
          haraka_done <= 1'b0;
          keccak_done <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

`ifdef HASH_SEQ_PERF_EN
  // perf_busy_cycles counts the cycles of each operation measured from the IDLE
  // cycle that grants it, so one operation adds exactly its request-to-done
  // latency: 13 cycles for Haraka and 27 cycles for Keccak.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_haraka_cnt  <= '0;
      perf_keccak_cnt  <= '0;
      perf_busy_cycles <= '0;
    end else begin
      if (state == DONE && haraka_done) perf_haraka_cnt <= perf_haraka_cnt + 32'd1;
      if (state == DONE && keccak_done) perf_keccak_cnt <= perf_keccak_cnt + 32'd1;
      if (state != IDLE || haraka_req || keccak_req)
        perf_busy_cycles <= perf_busy_cycles + 32'd1;
    end
  end
`endif

endmodule
